// File: rtl/axi_line_transfer_engine_pkg.sv
// rtl/axi_line_transfer_engine_pkg.sv - shared line/AXI types and engine state encoding
package axi_line_transfer_engine_pkg;

  localparam int CACHE_LINE_BITS        = 512;
  localparam int AXI_DATA_WIDTH_DEFAULT = 32;
  localparam int LINE_OFFSET_BITS       = 6;

  typedef logic [25:0]                cache_line_index_t;
  typedef logic [CACHE_LINE_BITS-1:0] cache_line_data_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;

  // Plain vector encoding keeps the state compatible with legacy tooling.
  typedef logic [2:0] axi_engine_state_t;
  localparam axi_engine_state_t ST_IDLE       = 3'd0;
  localparam axi_engine_state_t ST_READ_ADDR  = 3'd1;
  localparam axi_engine_state_t ST_READ_DATA  = 3'd2;
  localparam axi_engine_state_t ST_WRITE_ADDR = 3'd3;
  localparam axi_engine_state_t ST_WRITE_DATA = 3'd4;
  localparam axi_engine_state_t ST_WRITE_RESP = 3'd5;
  localparam axi_engine_state_t ST_RESPOND    = 3'd6;

  typedef logic [$clog2(CACHE_LINE_BITS/AXI_DATA_WIDTH_DEFAULT)-1:0] beat_idx_t;

endpackage

// File: rtl/axi_line_transfer_engine.sv
// rtl/axi_line_transfer_engine.sv - one cache line fill/writeback as a single AXI4 INCR burst
module axi_line_transfer_engine
  import axi_line_transfer_engine_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_is_write,
  input  logic [25:0]                 req_line,
  input  logic [CACHE_LINE_BITS-1:0]  req_data,
  output logic                        rsp_valid,
  output logic                        rsp_is_write,
  output logic [CACHE_LINE_BITS-1:0]  rsp_data,
  output logic [31:0]                 m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic [3:0]                  m_arcache,
  output logic                        m_arvalid,
  input  logic                        s_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  input  logic                        s_rvalid,
  output logic                        m_rready,
  output logic [31:0]                 m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic [3:0]                  m_awcache,
  output logic                        m_awvalid,
  input  logic                        s_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        s_wready,
  input  logic                        s_bvalid,
  output logic                        m_bready
);

  localparam int BURST_BEATS = CACHE_LINE_BITS / AXI_DATA_WIDTH;
  localparam int BEAT_W      = $clog2(BURST_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);

  axi_engine_state_t        state;
  cache_line_index_t        line_q;
  logic                     is_write_q;
  cache_line_data_t         shift_q;
  logic [BEAT_W-1:0]        beat_q;
  cache_line_data_t         shift_in;

  // Beats enter at the LSB and migrate up, so the first (lowest address) beat ends at the MSB.
  assign shift_in = {shift_q[CACHE_LINE_BITS-AXI_DATA_WIDTH-1:0], s_rdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      line_q     <= '0;
      is_write_q <= 1'b0;
      shift_q    <= '0;
      beat_q     <= '0;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            line_q     <= req_line;
            is_write_q <= req_is_write;
            shift_q    <= req_data;
            beat_q     <= '0;
            state      <= req_is_write ? ST_WRITE_ADDR : ST_READ_ADDR;
          end
        end
        ST_READ_ADDR: begin
          if (s_arready) state <= ST_READ_DATA;
        end
        ST_READ_DATA: begin
          if (s_rvalid) begin
            shift_q <= shift_in;
            beat_q  <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
              rsp_data <= shift_in;
              state    <= ST_RESPOND;
            end
          end
        end
        ST_WRITE_ADDR: begin
          if (s_awready) state <= ST_WRITE_DATA;
        end
        ST_WRITE_DATA: begin
          if (s_wready) begin
            shift_q <= {shift_q[CACHE_LINE_BITS-AXI_DATA_WIDTH-1:0], {AXI_DATA_WIDTH{1'b0}}};
            beat_q  <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) state <= ST_WRITE_RESP;
          end
        end
        ST_WRITE_RESP: begin
          if (s_bvalid) state <= ST_RESPOND;
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (state == ST_IDLE);
  assign rsp_valid    = (state == ST_RESPOND);
  assign rsp_is_write = is_write_q;

  assign m_araddr  = {line_q, {LINE_OFFSET_BITS{1'b0}}};
  assign m_arlen   = 8'(BURST_BEATS - 1);
  assign m_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign m_arburst = AXI_BURST_INCR;
  assign m_arcache = 4'b0011;
  assign m_arvalid = (state == ST_READ_ADDR);
  assign m_rready  = (state == ST_READ_DATA);

  assign m_awaddr  = {line_q, {LINE_OFFSET_BITS{1'b0}}};
  assign m_awlen   = 8'(BURST_BEATS - 1);
  assign m_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign m_awburst = AXI_BURST_INCR;
  assign m_awcache = 4'b0011;
  assign m_awvalid = (state == ST_WRITE_ADDR);

  // W stays quiet until the AW handshake has completed.
  assign m_wvalid = (state == ST_WRITE_DATA);
  assign m_wdata  = shift_q[CACHE_LINE_BITS-1 -: AXI_DATA_WIDTH];
  assign m_wstrb  = '1;
  assign m_wlast  = m_wvalid && (beat_q == LAST_BEAT);
  assign m_bready = (state == ST_WRITE_RESP);

endmodule

// File: tb/tb_axi_line_transfer_engine.sv
// tb/tb_axi_line_transfer_engine.sv - directed self-checking bench for axi_line_transfer_engine
module tb_axi_line_transfer_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_is_write;
  logic [25:0]  req_line;
  logic [511:0] req_data;
  logic         rsp_valid, rsp_is_write;
  logic [511:0] rsp_data;
  logic [31:0]  m_araddr, m_awaddr;
  logic [7:0]   m_arlen, m_awlen;
  logic [2:0]   m_arsize, m_awsize;
  logic [1:0]   m_arburst, m_awburst;
  logic [3:0]   m_arcache, m_awcache;
  logic         m_arvalid, s_arready, s_rvalid, m_rready;
  logic [31:0]  s_rdata, m_wdata;
  logic         m_awvalid, s_awready;
  logic [3:0]   m_wstrb;
  logic         m_wlast, m_wvalid, s_wready, s_bvalid, m_bready;

  int checks = 0;
  int passed = 0;

  axi_line_transfer_engine dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
    .req_line(req_line), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_is_write(rsp_is_write), .rsp_data(rsp_data),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arcache(m_arcache), .m_arvalid(m_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awcache(m_awcache), .m_awvalid(m_awvalid), .s_awready(s_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k = base + k, word 0 at the MSB.
  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[511 - k*32 -: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic start_req(input logic wr, input logic [25:0] line, input logic [511:0] data);
    req_valid = 1'b1; req_is_write = wr; req_line = line; req_data = data;
    checks++; if (req_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", req_ready); else passed++;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else passed++;
    checks++; if ({m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready} !== 6'b0)
      $display("FAIL rst_axi_ctrl: got %b want 000000", {m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready}); else passed++;
    checks++; if (rsp_data !== 512'b0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else passed++;
  endtask

  task automatic test_read_basic();
    start_req(1'b0, 26'h0000040, '0);
    checks++; if (m_arvalid !== 1'b1) $display("FAIL rd_arvalid: got %b want 1", m_arvalid); else passed++;
    checks++; if (m_araddr !== 32'h00001000) $display("FAIL rd_araddr: got %h want 00001000", m_araddr); else passed++;
    checks++; if (m_arlen !== 8'd15) $display("FAIL rd_arlen: got %0d want 15", m_arlen); else passed++;
    checks++; if (m_arsize !== 3'd2) $display("FAIL rd_arsize: got %0d want 2", m_arsize); else passed++;
    checks++; if (m_arburst !== 2'b01) $display("FAIL rd_arburst: got %b want 01", m_arburst); else passed++;
    checks++; if (m_arcache !== 4'b0011) $display("FAIL rd_arcache: got %b want 0011", m_arcache); else passed++;
    checks++; if (req_ready !== 1'b0) $display("FAIL rd_busy_ready: got %b want 0", req_ready); else passed++;
    s_arready = 1'b1; tick(); s_arready = 1'b0;
    checks++; if (m_rready !== 1'b1) $display("FAIL rd_rready: got %b want 1", m_rready); else passed++;
    for (int k = 0; k < 16; k++) begin
      s_rvalid = 1'b1; s_rdata = 32'(k); tick();
    end
    s_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_is_write !== 1'b0) $display("FAIL rd_rsp_is_write: got %b want 0", rsp_is_write); else passed++;
    checks++; if (rsp_data[511:480] !== 32'h0) $display("FAIL rd_msb_word: got %h want 0", rsp_data[511:480]); else passed++;
    checks++; if (rsp_data[31:0] !== 32'hF) $display("FAIL rd_lsb_word: got %h want f", rsp_data[31:0]); else passed++;
    checks++; if (rsp_data !== mk_line(32'h0)) $display("FAIL rd_line: got %h want %h", rsp_data, mk_line(32'h0)); else passed++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rd_rsp_pulse: got %b want 0", rsp_valid); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL rd_idle_ready: got %b want 1", req_ready); else passed++;
  endtask

  task automatic do_write(input int stall_beat, input int stall_cycles, input string tag);
    start_req(1'b1, 26'h1, mk_line(32'hA000_0000));
    checks++; if (m_awvalid !== 1'b1) $display("FAIL %s_awvalid: got %b want 1", tag, m_awvalid); else passed++;
    checks++; if (m_awaddr !== 32'h40) $display("FAIL %s_awaddr: got %h want 00000040", tag, m_awaddr); else passed++;
    checks++; if ({m_awlen, m_awsize, m_awburst} !== {8'd15, 3'd2, 2'b01})
      $display("FAIL %s_aw_fields: got %h want %h", tag, {m_awlen, m_awsize, m_awburst}, {8'd15, 3'd2, 2'b01}); else passed++;
    checks++; if (m_wstrb !== 4'hF) $display("FAIL %s_wstrb: got %h want f", tag, m_wstrb); else passed++;
    s_wready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      checks++; if (m_wvalid !== 1'b0) $display("FAIL %s_w_before_aw: got %b want 0", tag, m_wvalid); else passed++;
      tick();
    end
    s_awready = 1'b1; tick(); s_awready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == stall_beat) begin
        s_wready = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
          tick();
          checks++; if (m_wvalid !== 1'b1 || m_wdata !== 32'hA000_0000 + 32'(k) || m_wlast !== 1'b0)
            $display("FAIL %s_stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=0", tag, m_wvalid, m_wdata, m_wlast, 32'hA000_0000 + 32'(k)); else passed++;
        end
        s_wready = 1'b1;
      end
      checks++; if (m_wvalid !== 1'b1) $display("FAIL %s_wvalid_b%0d: got %b want 1", tag, k, m_wvalid); else passed++;
      checks++; if (m_wdata !== 32'hA000_0000 + 32'(k)) $display("FAIL %s_wdata_b%0d: got %h want %h", tag, k, m_wdata, 32'hA000_0000 + 32'(k)); else passed++;
      checks++; if (m_wlast !== (k == 15)) $display("FAIL %s_wlast_b%0d: got %b want %b", tag, k, m_wlast, (k == 15)); else passed++;
      tick();
    end
    s_wready = 1'b0;
    checks++; if (m_bready !== 1'b1 || m_wvalid !== 1'b0) $display("FAIL %s_bready: got b=%b w=%b want b=1 w=0", tag, m_bready, m_wvalid); else passed++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL %s_rsp_before_b: got %b want 0", tag, rsp_valid); else passed++;
    s_bvalid = 1'b1; tick(); s_bvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_is_write !== 1'b1) $display("FAIL %s_rsp: got v=%b w=%b want v=1 w=1", tag, rsp_valid, rsp_is_write); else passed++;
    checks++; if (rsp_data !== mk_line(32'h0)) $display("FAIL %s_rsp_data_kept: got %h want %h", tag, rsp_data, mk_line(32'h0)); else passed++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL %s_rsp_pulse: got %b want 0", tag, rsp_valid); else passed++;
  endtask

  task automatic test_write_basic();
    do_write(-1, 0, "wr");
  endtask

  task automatic test_write_stall();
    do_write(7, 3, "wrstall");
  endtask

  task automatic test_read_backpressure();
    int beat;
    start_req(1'b0, 26'h0000040, '1);
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 5; c++) begin
      checks++; if (m_arvalid !== 1'b1 || m_araddr !== 32'h00001000)
        $display("FAIL bp_ar_hold: got v=%b a=%h want v=1 a=00001000", m_arvalid, m_araddr); else passed++;
      checks++; if (m_rready !== 1'b0) $display("FAIL bp_rready_early: got %b want 0", m_rready); else passed++;
      tick();
    end
    s_rvalid = 1'b0;
    s_arready = 1'b1; tick(); s_arready = 1'b0;
    beat = 0;
    for (int c = 0; c < 31; c++) begin
      checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_rsp_early: got %b want 0 at cycle %0d", rsp_valid, c); else passed++;
      if (c % 2 == 0) begin s_rvalid = 1'b1; s_rdata = 32'(beat); beat++; end
      else begin s_rvalid = 1'b0; s_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    s_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_data !== mk_line(32'h0)) $display("FAIL bp_line: got %h want %h", rsp_data, mk_line(32'h0)); else passed++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    start_req(1'b0, 26'h2, '0);
    s_arready = 1'b1; tick(); s_arready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_rvalid = 1'b1; s_rdata = 32'h7700_0000 + 32'(k); tick();
    end
    s_rvalid = 1'b0;
    reset = 1'b1; #1;
    test_reset();
    tick();
    checks++; if (req_ready !== 1'b1 || m_rready !== 1'b0) $display("FAIL midrst_held: got rdy=%b rr=%b want 1 0", req_ready, m_rready); else passed++;
    reset = 1'b0; tick();
    start_req(1'b0, 26'h3, '0);
    checks++; if (m_araddr !== 32'h000000C0) $display("FAIL midrst_araddr: got %h want 000000c0", m_araddr); else passed++;
    s_arready = 1'b1; tick(); s_arready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s_rvalid = 1'b1; s_rdata = 32'h100 + 32'(k); tick();
    end
    s_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL midrst_rsp_valid: got %b want 1", rsp_valid); else passed++;
    checks++; if (rsp_data !== mk_line(32'h100)) $display("FAIL midrst_line: got %h want %h", rsp_data, mk_line(32'h100)); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    req_valid = 1'b1; req_is_write = 1'b0; req_line = 26'h5; req_data = '0;
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h5A5A_5A5A;
    checks++; if (req_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b want 1", req_ready); else passed++;
    tick();
    lat = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      lat++;
      checks++; if (req_ready !== 1'b0) $display("FAIL b2b_busy_ready: got %b want 0 at cycle %0d", req_ready, c); else passed++;
      tick();
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) $display("FAIL b2b_timeout: got no rsp_valid want rsp_valid within 40 cycles"); else passed++;
    checks++; if (lat != 17) $display("FAIL b2b_latency: got %0d want 17", lat); else passed++;
    checks++; if (rsp_data !== {16{32'h5A5A_5A5A}}) $display("FAIL b2b_line: got %h want %h", rsp_data, {16{32'h5A5A_5A5A}}); else passed++;
    tick();
    checks++; if (req_ready !== 1'b1) $display("FAIL b2b_gap_ready: got %b want 1", req_ready); else passed++;
    tick();
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || m_arvalid !== 1'b1) $display("FAIL b2b_second_accept: got rdy=%b arv=%b want 0 1", req_ready, m_arvalid); else passed++;
    for (int c = 0; c < 17; c++) tick();
    checks++; if (rsp_valid !== 1'b1) $display("FAIL b2b_second_rsp: got %b want 1", rsp_valid); else passed++;
    s_arready = 1'b0; s_rvalid = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_is_write = 1'b0; req_line = '0; req_data = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_read_basic();
    test_write_basic();
    test_read_backpressure();
    test_write_stall();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
